// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, parity modes, frame limits.
// The receiver imports the same parity encodings and frame limits.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned FRAME_MIN  = 5;
  localparam int unsigned FRAME_MAX  = 8;
  localparam int unsigned LEN_W      = 4;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_EVEN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_DONE
  } tx_state_e;

  // Frame configuration captured when a word is accepted
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             stop2;
    logic [1:0]       par;
  } tx_cfg_t;

  // Out-of-range frame lengths snap to the nearest legal value
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] fl);
    if (fl < LEN_W'(FRAME_MIN)) begin
      return LEN_W'(FRAME_MIN);
    end
    if (fl > LEN_W'(FRAME_MAX)) begin
      return LEN_W'(FRAME_MAX);
    end
    return fl;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Oversample counter for one UART bit period; bit_end_c flags the final tick.
// Held at zero while disabled so every bit period starts from a clean count.
module uart_tx_bit_timer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic bit_end_c
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin : count_next
    count_d   = count_q;
    bit_end_c = en_i && (count_q == CNT_W'(OVERSAMPLE - 1));
    if (!en_i || bit_end_c) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin : count_reg
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: serializes one DATA_WIDTH word as back-to-back frames
// (start, L data bits LSB-first, optional parity, 1-2 stop bits) on TX.
module uart_tx_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                  tx_tick,
  input  logic                  PRESETn,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic                  tx_valid,
  input  logic [3:0]            frame_length,
  input  logic                  stop_bit,
  input  logic [1:0]            parity,
  output logic                  tx_ready,
  output logic                  TX,
  output logic                  tx_busy,
  output logic                  tx_done
);

  import uart_pkg::*;

  localparam int unsigned FC_W  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned IDX_W = FC_W + LEN_W;
  localparam int unsigned NF5   = (DATA_WIDTH + 4) / 5;
  localparam int unsigned NF6   = (DATA_WIDTH + 5) / 6;
  localparam int unsigned NF7   = (DATA_WIDTH + 6) / 7;
  localparam int unsigned NF8   = (DATA_WIDTH + 7) / 8;

  tx_state_e             state_q, state_d;
  tx_cfg_t               cfg_q, cfg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [FC_W-1:0]       frame_q, frame_d;
  logic [FC_W-1:0]       last_q, last_d;
  logic [LEN_W-1:0]      bit_q, bit_d;
  logic                  par_acc_q, par_acc_d;
  logic                  tx_q, tx_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  tx_busy_q, tx_busy_d;
  logic                  tx_done_q, tx_done_d;

  logic                  accept_c;
  logic                  timer_en_c;
  logic                  bit_end_c;
  logic [LEN_W-1:0]      len_in_c;
  logic [IDX_W-1:0]      bit_idx_c;
  logic                  data_bit_c;

  // Index of the final frame for a given (already clamped) frame length
  function automatic logic [FC_W-1:0] last_frame(input logic [LEN_W-1:0] len);
    case (len)
      LEN_W'(5): return FC_W'(NF5 - 1);
      LEN_W'(6): return FC_W'(NF6 - 1);
      LEN_W'(7): return FC_W'(NF7 - 1);
      default:   return FC_W'(NF8 - 1);
    endcase
  endfunction

  assign timer_en_c = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign accept_c   = (state_q == ST_IDLE) && tx_valid && tx_ready_q;
  assign len_in_c   = clamp_len(frame_length);

  uart_tx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk       (tx_tick),
    .rst_n     (PRESETn),
    .en_i      (timer_en_c),
    .bit_end_c (bit_end_c)
  );

  always_comb begin : fsm_next
    state_d   = state_q;
    cfg_d     = cfg_q;
    data_d    = data_q;
    frame_d   = frame_q;
    last_d    = last_q;
    bit_d     = bit_q;
    par_acc_d = par_acc_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d   = ST_START;
          data_d    = tx_data_in;
          cfg_d.len   = len_in_c;
          cfg_d.stop2 = stop_bit;
          cfg_d.par   = parity;
          last_d    = last_frame(len_in_c);
          frame_d   = '0;
          bit_d     = '0;
          par_acc_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          state_d   = ST_DATA;
          bit_d     = '0;
          par_acc_d = 1'b0;
        end
      end
      ST_DATA: begin
        // tx_q holds the data bit being retired, pads included
        if (bit_end_c) begin
          par_acc_d = par_acc_q ^ tx_q;
          if (bit_q == cfg_q.len - LEN_W'(1)) begin
            bit_d   = '0;
            state_d = cfg_q.par[1] ? ST_PARITY : ST_STOP1;
          end else begin
            bit_d = bit_q + LEN_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end_c) begin
          state_d = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (bit_end_c) begin
          if (cfg_q.stop2) begin
            state_d = ST_STOP2;
          end else if (frame_q == last_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_START;
            frame_d = frame_q + FC_W'(1);
          end
        end
      end
      ST_STOP2: begin
        if (bit_end_c) begin
          if (frame_q == last_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_START;
            frame_d = frame_q + FC_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Word bit for the upcoming data slot; positions past the word send 0
  always_comb begin : data_bit_sel
    bit_idx_c  = IDX_W'(frame_d) * IDX_W'(cfg_q.len) + IDX_W'(bit_d);
    data_bit_c = 1'b0;
    for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
      if (bit_idx_c == IDX_W'(j)) begin
        data_bit_c = data_q[j];
      end
    end
  end

  always_comb begin : out_next
    tx_d       = 1'b1;
    tx_ready_d = (state_d == ST_IDLE);
    tx_busy_d  = (state_d != ST_IDLE);
    tx_done_d  = (state_d == ST_DONE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_bit_c;
      ST_PARITY: tx_d = (cfg_q.par == PAR_ODD) ? ~par_acc_d : par_acc_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge tx_tick) begin : state_reg
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      data_q     <= '0;
      frame_q    <= '0;
      last_q     <= '0;
      bit_q      <= '0;
      par_acc_q  <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      data_q     <= data_d;
      frame_q    <= frame_d;
      last_q     <= last_d;
      bit_q      <= bit_d;
      par_acc_q  <= par_acc_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign TX       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: cycle-exact TX waveform against a frame
// model, plus hand-computed completion times, decoded words and parity bits.
module tb_uart_tx_engine;

  logic        tx_tick;
  logic        PRESETn;
  logic [31:0] tx_data_in;
  logic        tx_valid;
  logic [3:0]  frame_length;
  logic        stop_bit;
  logic [1:0]  parity;
  logic        tx_ready;
  logic        TX;
  logic        tx_busy;
  logic        tx_done;

  int n_tests = 0;
  int n_fail  = 0;

  bit exp_bits[$];
  bit obs_bits[$];

  uart_tx_engine #(
    .DATA_WIDTH (32),
    .OVERSAMPLE (16)
  ) dut (
    .tx_tick      (tx_tick),
    .PRESETn      (PRESETn),
    .tx_data_in   (tx_data_in),
    .tx_valid     (tx_valid),
    .frame_length (frame_length),
    .stop_bit     (stop_bit),
    .parity       (parity),
    .tx_ready     (tx_ready),
    .TX           (TX),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  initial tx_tick = 1'b0;
  always #5 tx_tick = ~tx_tick;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_tick);
    #1;
  endtask

  function automatic logic [31:0] line_state();
    return {28'd0, TX, tx_busy, tx_done, tx_ready};
  endfunction

  // Reference bit-period stream for one word
  task automatic build_stream(input logic [31:0] w, input int fl, input bit sb,
                              input logic [1:0] par);
    int l;
    int nf;
    bit p;
    bit bt;
    logic [31:0] sh;
    l  = (fl < 5) ? 5 : ((fl > 8) ? 8 : fl);
    nf = (32 + l - 1) / l;
    exp_bits.delete();
    for (int f = 0; f < nf; f++) begin
      exp_bits.push_back(1'b0);
      p = 1'b0;
      for (int b = 0; b < l; b++) begin
        sh = w >> (f * l + b);
        bt = ((f * l + b) < 32) ? sh[0] : 1'b0;
        p  = p ^ bt;
        exp_bits.push_back(bt);
      end
      if (par[1]) exp_bits.push_back((par == 2'b10) ? ~p : p);
      exp_bits.push_back(1'b1);
      if (sb) exp_bits.push_back(1'b1);
    end
  endtask

  // Rebuild the word and per-frame parity bits from mid-bit TX samples
  task automatic decode(input int fbits, input int l, output logic [31:0] word,
                        output logic [7:0] pv);
    int nf;
    nf   = obs_bits.size() / fbits;
    word = '0;
    pv   = '0;
    for (int f = 0; f < nf; f++) begin
      for (int b = 0; b < l; b++) begin
        if ((f * l + b) < 32) word = word | (32'(obs_bits[f * fbits + 1 + b]) << (f * l + b));
      end
      if ((1 + l) < fbits) pv = pv | (8'(obs_bits[f * fbits + 1 + l]) << f);
    end
  endtask

  task automatic xfer(input string nm, input logic [31:0] w, input logic [3:0] fl,
                      input bit sb, input logic [1:0] par, input int exp_done,
                      input bit hold, input logic [31:0] w2, input logic [3:0] fl2,
                      input bit sb2, input logic [1:0] par2, input int abort_at);
    int n;
    int done_cyc;
    logic [31:0] exp_t;
    done_cyc = 0;
    build_stream(w, int'(fl), sb, par);
    n = exp_bits.size() * 16;
    obs_bits.delete();
    check_eq({nm, "_rdy_pre"}, 32'(tx_ready), 32'd1);
    tx_data_in   = w;
    frame_length = fl;
    stop_bit     = sb;
    parity       = par;
    tx_valid     = 1'b1;
    tick();
    if (!hold) tx_valid = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      if (abort_at != 0 && c == abort_at) begin
        PRESETn = 1'b0;
        tick();
        check_eq({nm, "_rst_edge"}, line_state(), 32'h8);
        PRESETn = 1'b1;
        tick();
        check_eq({nm, "_rst_after"}, line_state(), 32'h9);
        tick();
        check_eq({nm, "_rst_idle"}, line_state(), 32'h9);
        return;
      end
      if (hold && c == 50) begin
        tx_data_in   = w2;
        frame_length = fl2;
        stop_bit     = sb2;
        parity       = par2;
      end
      if (c <= n) exp_t = {28'd0, exp_bits[(c - 1) / 16], 3'b100};
      else if (c == n + 1) exp_t = 32'hE;
      else exp_t = 32'h9;
      check_eq($sformatf("%s_c%0d", nm, c), line_state(), exp_t);
      if (c % 16 == 8 && c <= n) obs_bits.push_back(TX);
      if (tx_done && done_cyc == 0) done_cyc = c;
      if (c < n + 2) tick();
    end
    check_eq({nm, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
  endtask

  initial begin
    logic [31:0] word;
    logic [7:0]  pv;
    PRESETn      = 1'b0;
    tx_valid     = 1'b0;
    tx_data_in   = '0;
    frame_length = 4'd8;
    stop_bit     = 1'b0;
    parity       = 2'b00;
    tick();
    tick();
    check_eq("reset_state", line_state(), 32'h8);
    PRESETn = 1'b1;
    tick();
    check_eq("post_reset_ready", line_state(), 32'h9);

    xfer("l8_np_1s", 32'hA5C3_0F81, 4'd8, 1'b0, 2'b00, 641, 1'b0, '0, 4'd0, 1'b0, 2'b00, 0);
    decode(10, 8, word, pv);
    check_eq("l8_np_1s_word", word, 32'hA5C3_0F81);

    xfer("l8_ev_2s", 32'hA5C3_0F81, 4'd8, 1'b1, 2'b11, 769, 1'b0, '0, 4'd0, 1'b0, 2'b00, 0);
    decode(12, 8, word, pv);
    check_eq("l8_ev_2s_word", word, 32'hA5C3_0F81);
    check_eq("l8_ev_2s_par", 32'(pv), 32'h00);

    xfer("l5_od_1s", 32'h0000_0007, 4'd5, 1'b0, 2'b10, 897, 1'b0, '0, 4'd0, 1'b0, 2'b00, 0);
    decode(8, 5, word, pv);
    check_eq("l5_od_1s_word", word, 32'h0000_0007);
    check_eq("l5_od_1s_par", 32'(pv), 32'h7E);

    xfer("fl3_clamp", 32'h1234_5678, 4'd3, 1'b0, 2'b00, 785, 1'b0, '0, 4'd0, 1'b0, 2'b00, 0);
    decode(7, 5, word, pv);
    check_eq("fl3_clamp_word", word, 32'h1234_5678);

    xfer("fl12_clamp", 32'hDEAD_BEEF, 4'd12, 1'b1, 2'b11, 769, 1'b0, '0, 4'd0, 1'b0, 2'b00, 0);
    decode(12, 8, word, pv);
    check_eq("fl12_clamp_word", word, 32'hDEAD_BEEF);
    check_eq("fl12_clamp_par", 32'(pv), 32'h05);

    xfer("hold_w1", 32'h0F0F_F0F0, 4'd6, 1'b0, 2'b10, 865, 1'b1,
         32'h0000_003C, 4'd7, 1'b1, 2'b11, 0);
    decode(9, 6, word, pv);
    check_eq("hold_w1_word", word, 32'h0F0F_F0F0);
    check_eq("hold_w1_par", 32'(pv), 32'h3F);
    xfer("hold_w2", 32'h0000_003C, 4'd7, 1'b1, 2'b11, 881, 1'b0, '0, 4'd0, 1'b0, 2'b00, 0);
    decode(11, 7, word, pv);
    check_eq("hold_w2_word", word, 32'h0000_003C);
    check_eq("hold_w2_par", 32'(pv), 32'h00);

    xfer("abort", 32'hFFFF_FFFF, 4'd8, 1'b0, 2'b00, 641, 1'b0, '0, 4'd0, 1'b0, 2'b00, 380);
    xfer("fresh", 32'h5555_AAAA, 4'd7, 1'b0, 2'b00, 721, 1'b0, '0, 4'd0, 1'b0, 2'b00, 0);
    decode(9, 7, word, pv);
    check_eq("fresh_word", word, 32'h5555_AAAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- UART transmit engine; the transmit-direction counterpart of the block-level UART receiver in the same APB UART.
- Accepts one DATA_WIDTH-bit word from the APB/FIFO side and serializes it as back-to-back UART frames on TX. Each frame is start, frame_length data bits LSB-first, optional parity, and 1 or 2 stop bits.
- The frame sequence matches what the receiver reassembles into one word.
- Clocked by the 16x-oversampled baud tick.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (32): width of the word carried by one frame sequence.
- OVERSAMPLE, 16: tx_tick cycles per UART bit.

Ports:
- tx_tick  in  1  clock, 16x baud tick.
- PRESETn  in  1  reset; synchronous, active-low.
- tx_data_in  in  DATA_WIDTH  word to transmit.
- tx_valid  in  1  word available.
- frame_length  in  4  data bits per frame; legal 5..8.
- stop_bit  in  1  0 = one stop bit, 1 = two stop bits.
- parity  in  2  [1] = enable; 2'b10 = odd, 2'b11 = even.
- tx_ready  out  1  engine can accept a word.
- TX  out  1  serial line; idles high.
- tx_busy  out  1  frame sequence in progress.
- tx_done  out  1  one-cycle pulse, word fully sent.

Behaviour:
- Interface fixed: one clock tx_tick; reset PRESETn, synchronous, active-low. Sampled only on posedge tx_tick.
- Reset values: TX=1, tx_ready=0 during reset (1 from first cycle after), tx_busy=0, tx_done=0, state IDLE, all counters 0.
- Reset mid-frame: sequence aborted; TX=1 at that edge; no tx_done.
- All outputs are registered.
- Handshake: accept when state==IDLE && tx_valid && tx_ready. On acceptance, tx_data_in, frame_length, stop_bit and parity are latched into shadow registers. Input changes during a sequence have no effect.
- tx_ready=1 only in IDLE. tx_valid without tx_ready is ignored, not queued.
- frame_length outside 5..8 is clamped: values <5 are treated as 5, values >8 as 8.
- Frame count: NF = ceil(DATA_WIDTH / L).
  - Bits are taken from word bit 0 upward.
  - Any unfilled bit positions in the last frame are sent as 0.
  - Parity covers the L bits actually sent, including pads.
- Parity bit value: odd mode sends ~^bits; even mode sends ^bits.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
  - IDLE: TX=1. On acceptance -> START, with TX=0 from the next edge.
  - START: 16 ticks at 0 -> DATA.
  - DATA: each bit held 16 ticks; bit_count 0..L-1. After the last bit -> PARITY if enabled, else STOP1.
  - PARITY: 16 ticks -> STOP1.
  - STOP1: 16 ticks at 1. Then -> STOP2 if stop_bit=1; else -> START if frames remain; else -> DONE.
  - STOP2: 16 ticks at 1. Then -> START if frames remain, else -> DONE.
  - DONE: one cycle with tx_done=1 and TX=1 -> IDLE.
- Frames are back-to-back: no idle gap between the last stop tick and the next start bit.
- Timing: the first START cycle is 1 edge after acceptance. The sequence duration is NF*16*(1+L+P+S) ticks, where P = parity enabled (0/1) and S = 1 or 2 stop bits. tx_done follows on the next cycle; tx_ready rises the cycle after tx_done.
- tick_count is 4 bits and wraps 15->0 at each bit boundary. bit_count is 4 bits. frame_count is $clog2(DATA_WIDTH+1) bits.
- Word bit index = frame_count*L + bit_count. An index >= DATA_WIDTH sends 0.
- tx_busy = 1 in every state except IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - state enum tx_state_e;
  - parity encodings PAR_NONE, PAR_ODD=2'b10, PAR_EVEN=2'b11;
  - FRAME_MIN=5, FRAME_MAX=8, OVERSAMPLE.
  - The receiver is to share the parity encodings.
- One natural sub-module: uart_tx_bit_timer, the 16-tick counter with a bit_end strobe, reusable by the receiver.
- Shift, parity and frame logic stay in the top level.

Test Plan:
- Word 0xA5C3_0F81, L=8, no parity, 1 stop -> 4 frames of 160 ticks each. LSB-first bytes 0x81, 0x0F, 0xC3, 0xA5. tx_done at tick 641 after acceptance.
- Same word, L=8, even parity, 2 stop -> parity bits 0, 0, 0, 0 (each byte has an even number of 1s). Each frame is 192 ticks. No gap between frames.
- 0x0000_0007, L=5, odd parity, 1 stop -> 7 frames. Frame 0 data is 11100 with parity 0. Frame 6 is 2 real bits plus 3 zero pads with parity 1.
- frame_length=3 and frame_length=12 -> behave exactly as L=5 and L=8 respectively.
- tx_valid held high, with tx_data_in and config changed mid-sequence -> in-flight frames unchanged. The second word is accepted only in IDLE after tx_done.
- PRESETn=0 for one tick midway through DATA of frame 2 -> TX=1 on that edge, no tx_done, tx_ready=1 the next cycle. A fresh word then transmits correctly.
